// File: rtl/spw_pio_link_bridge.sv
// Bridge between level-based Qsys PIO handshakes and the strobe-based FIFO-less SpaceWire codec.
// Optional time-code paths are compiled in with `define SPW_PIO_TIMECODE_EN.

module spw_pio_tx_path #(
   parameter int W           = 9,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         arm,
   input  logic         req,
   input  logic [W-1:0] req_data,
   input  logic         codec_ready,
   output logic         codec_write,
   output logic [W-1:0] codec_data,
   output logic         sw_ready,
   output logic         timeout
);
   typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_STROBE, TX_DONE} tx_state_t;

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   tx_state_t        state_r, state_nx_s;
   logic             req_prev_r;
   logic             rise_s;
   logic             expire_s;
   logic [CNT_W-1:0] cnt_r;
   logic [W-1:0]     data_r;
   logic             write_r, ready_r, timeout_r;

   assign rise_s      = arm & req & ~req_prev_r;
   assign codec_write = write_r;
   assign codec_data  = data_r;
   assign sw_ready    = ready_r;
   assign timeout     = timeout_r;

   // Next-state logic; dropping the request level in WAIT aborts silently
   always_comb begin
      state_nx_s = state_r;
      expire_s   = 1'b0;
      case (state_r)
         TX_IDLE: begin
            if (rise_s) state_nx_s = TX_WAIT;
            else        state_nx_s = TX_IDLE;
         end
         TX_WAIT: begin
            if (!req) begin
               state_nx_s = TX_IDLE;
            end else if (codec_ready) begin
               state_nx_s = TX_STROBE;
            end else if ((TIMEOUT_CYC != 0) && (cnt_r == CNT_LAST)) begin
               expire_s   = 1'b1;
               state_nx_s = TX_IDLE;
            end else begin
               state_nx_s = TX_WAIT;
            end
         end
         TX_STROBE: state_nx_s = TX_DONE;
         TX_DONE: begin
            if (!req) state_nx_s = TX_IDLE;
            else      state_nx_s = TX_DONE;
         end
         default: state_nx_s = TX_IDLE;
      endcase
   end

   // State register, registered outputs decoded from the next state, timeout counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= TX_IDLE;
         req_prev_r <= 1'b0;
         cnt_r      <= '0;
         data_r     <= '0;
         write_r    <= 1'b0;
         ready_r    <= 1'b0;
         timeout_r  <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         req_prev_r <= req;
         write_r    <= (state_nx_s == TX_STROBE);
         ready_r    <= (state_nx_s == TX_DONE);
         if ((state_r == TX_IDLE) && rise_s) begin
            data_r <= req_data;
            cnt_r  <= '0;
         end else if (state_r == TX_WAIT) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
         if (rise_s)        timeout_r <= 1'b0;
         else if (expire_s) timeout_r <= 1'b1;
      end
   end
endmodule

module spw_pio_link_bridge #(
   parameter int DATA_W      = 9,
   parameter int TC_W        = 8,
   parameter int TIMEOUT_CYC = 1023,
   parameter int OVR_W       = 8
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [DATA_W-1:0] sw_tx_data,
   input  logic              sw_tx_en,
   output logic              sw_tx_ready,
   output logic              tx_timeout,
   input  logic              codec_tx_ready,
   output logic              codec_tx_write,
   output logic [DATA_W-1:0] codec_tx_data,
   input  logic              codec_rx_valid,
   input  logic [DATA_W-1:0] codec_rx_data,
   output logic [DATA_W-1:0] sw_rx_data,
   output logic              sw_rx_ready,
   input  logic              sw_rx_ack,
`ifdef SPW_PIO_TIMECODE_EN
   input  logic [TC_W-1:0]   sw_tc_data,
   input  logic              sw_tc_en,
   output logic              sw_tc_ready,
   output logic              codec_tc_write,
   output logic [TC_W-1:0]   codec_tc_data,
   input  logic              codec_tc_ready,
   input  logic              codec_tc_valid,
   input  logic [TC_W-1:0]   codec_tc_rx,
   output logic [TC_W-1:0]   sw_tc_rx,
   output logic              sw_tc_rx_ready,
`endif
   output logic [OVR_W-1:0]  rx_overrun_cnt
);
   logic              arm_r;
   logic              ack_prev_r;
   logic              ack_rise_s;
   logic              rx_take_s, rx_drop_s;
   logic [DATA_W-1:0] rx_data_r;
   logic              rx_ready_r;
   logic [OVR_W-1:0]  ovr_r;

   // Edge detectors only arm one cycle after reset so a level held through reset is not a rise
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) arm_r <= 1'b0;
      else                arm_r <= 1'b1;
   end

   spw_pio_tx_path #(.W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) u_tx (
      .clk         (clk_clk),
      .rst_n       (reset_reset_n),
      .arm         (arm_r),
      .req         (sw_tx_en),
      .req_data    (sw_tx_data),
      .codec_ready (codec_tx_ready),
      .codec_write (codec_tx_write),
      .codec_data  (codec_tx_data),
      .sw_ready    (sw_tx_ready),
      .timeout     (tx_timeout)
   );

   assign ack_rise_s = arm_r & sw_rx_ack & ~ack_prev_r;

   // An ack rise frees the holding register in the same cycle a new char may arrive
   always_comb begin
      rx_take_s = 1'b0;
      rx_drop_s = 1'b0;
      if (codec_rx_valid) begin
         rx_take_s = ~rx_ready_r | ack_rise_s;
         rx_drop_s = rx_ready_r & ~ack_rise_s;
      end else begin
         rx_take_s = 1'b0;
         rx_drop_s = 1'b0;
      end
   end

   // RX holding register and saturating overrun counter
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         ack_prev_r <= 1'b0;
         rx_data_r  <= '0;
         rx_ready_r <= 1'b0;
         ovr_r      <= '0;
      end else begin
         ack_prev_r <= sw_rx_ack;
         if (rx_take_s) begin
            rx_data_r  <= codec_rx_data;
            rx_ready_r <= 1'b1;
         end else if (ack_rise_s) begin
            rx_ready_r <= 1'b0;
         end
         if (rx_drop_s && (ovr_r != {OVR_W{1'b1}})) ovr_r <= ovr_r + OVR_W'(1);
      end
   end

   assign sw_rx_data     = rx_data_r;
   assign sw_rx_ready    = rx_ready_r;
   assign rx_overrun_cnt = ovr_r;

`ifdef SPW_PIO_TIMECODE_EN
   logic [TC_W-1:0] tc_rx_r;
   logic            tc_rx_ready_r;

   spw_pio_tx_path #(.W(TC_W), .TIMEOUT_CYC(TIMEOUT_CYC)) u_tc_tx (
      .clk         (clk_clk),
      .rst_n       (reset_reset_n),
      .arm         (arm_r),
      .req         (sw_tc_en),
      .req_data    (sw_tc_data),
      .codec_ready (codec_tc_ready),
      .codec_write (codec_tc_write),
      .codec_data  (codec_tc_data),
      .sw_ready    (sw_tc_ready),
      .timeout     ()
   );

   // Newest received time-code always overwrites the held one
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         tc_rx_r       <= '0;
         tc_rx_ready_r <= 1'b0;
      end else if (codec_tc_valid) begin
         tc_rx_r       <= codec_tc_rx;
         tc_rx_ready_r <= 1'b1;
      end
   end

   assign sw_tc_rx       = tc_rx_r;
   assign sw_tc_rx_ready = tc_rx_ready_r;
`endif
endmodule

// File: tb/tb_spw_pio_link_bridge.sv
// Self-checking bench for spw_pio_link_bridge (default build, time-code paths absent).
module tb_spw_pio_link_bridge;
   localparam int DW  = 9;
   localparam int TMO = 16;
   localparam int OW  = 2;

   logic          clk = 1'b0;
   logic          reset_reset_n;
   logic [DW-1:0] sw_tx_data;
   logic          sw_tx_en;
   logic          sw_tx_ready;
   logic          tx_timeout;
   logic          codec_tx_ready;
   logic          codec_tx_write;
   logic [DW-1:0] codec_tx_data;
   logic          codec_rx_valid;
   logic [DW-1:0] codec_rx_data;
   logic [DW-1:0] sw_rx_data;
   logic          sw_rx_ready;
   logic          sw_rx_ack;
   logic [OW-1:0] rx_overrun_cnt;

   int tests = 0;
   int fails = 0;

   // reference model state
   bit            m_held;
   logic [DW-1:0] m_data;
   int            m_ovr;
   bit            m_ack_prev;
   bit            m_tmo;

   always #5 clk = ~clk;

   spw_pio_link_bridge #(.DATA_W(DW), .TC_W(8), .TIMEOUT_CYC(TMO), .OVR_W(OW)) dut (
      .clk_clk        (clk),
      .reset_reset_n  (reset_reset_n),
      .sw_tx_data     (sw_tx_data),
      .sw_tx_en       (sw_tx_en),
      .sw_tx_ready    (sw_tx_ready),
      .tx_timeout     (tx_timeout),
      .codec_tx_ready (codec_tx_ready),
      .codec_tx_write (codec_tx_write),
      .codec_tx_data  (codec_tx_data),
      .codec_rx_valid (codec_rx_valid),
      .codec_rx_data  (codec_rx_data),
      .sw_rx_data     (sw_rx_data),
      .sw_rx_ready    (sw_rx_ready),
      .sw_rx_ack      (sw_rx_ack),
      .rx_overrun_cnt (rx_overrun_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " write"},   32'(codec_tx_write), 32'd0);
      chk({tag, " txdata"},  32'(codec_tx_data), 32'd0);
      chk({tag, " txready"}, 32'(sw_tx_ready), 32'd0);
      chk({tag, " timeout"}, 32'(tx_timeout), 32'd0);
      chk({tag, " rxready"}, 32'(sw_rx_ready), 32'd0);
      chk({tag, " rxdata"},  32'(sw_rx_data), 32'd0);
      chk({tag, " ovr"},     32'(rx_overrun_cnt), 32'd0);
   endtask

   task automatic model_reset();
      m_held = 1'b0; m_data = '0; m_ovr = 0; m_ack_prev = 1'b0; m_tmo = 1'b0;
   endtask

   task automatic release_reset();
      reset_reset_n = 1'b1;
      tick();
      tick();
   endtask

   // One TX request; codec_tx_ready is first seen dly cycles after WAIT is entered
   task automatic tx_xfer(input logic [DW-1:0] dat, input int dly);
      int  last;
      bit  exp_w, exp_r;
      last = (dly < TMO) ? dly + 4 : TMO + 3;
      sw_tx_data     = dat;
      sw_tx_en       = 1'b1;
      codec_tx_ready = 1'b0;
      for (int k = 1; k <= last; k++) begin
         tick();
         exp_w = (dly < TMO) && (k == dly + 2);
         exp_r = (dly < TMO) && (k >= dly + 3);
         m_tmo = (dly >= TMO) && (k >= TMO + 1);
         chk("tx write", 32'(codec_tx_write), 32'(exp_w));
         chk("tx ready", 32'(sw_tx_ready), 32'(exp_r));
         chk("tx timeout", 32'(tx_timeout), 32'(m_tmo));
         if (exp_w) chk("tx data", 32'(codec_tx_data), 32'(dat));
         codec_tx_ready = (k >= dly + 1);
      end
      sw_tx_en       = 1'b0;
      codec_tx_ready = 1'b0;
      tick();
      chk("tx ready drop", 32'(sw_tx_ready), 32'd0);
      chk("tx write idle", 32'(codec_tx_write), 32'd0);
      chk("tx timeout hold", 32'(tx_timeout), 32'(m_tmo));
   endtask

   task automatic rx_cycle(input bit v, input logic [DW-1:0] d, input bit a);
      bit rise;
      codec_rx_valid = v;
      codec_rx_data  = d;
      sw_rx_ack      = a;
      rise       = a && !m_ack_prev;
      m_ack_prev = a;
      if (v && m_held && !rise && m_ovr < (1 << OW) - 1) m_ovr++;
      if (v && (!m_held || rise)) begin
         m_held = 1'b1;
         m_data = d;
      end else if (rise) begin
         m_held = 1'b0;
      end
      tick();
      chk("rx ready", 32'(sw_rx_ready), 32'(m_held));
      chk("rx data", 32'(sw_rx_data), 32'(m_data));
      chk("rx ovr", 32'(rx_overrun_cnt), 32'(m_ovr));
      codec_rx_valid = 1'b0;
   endtask

   initial begin
      reset_reset_n  = 1'b0;
      sw_tx_data     = '0;
      sw_tx_en       = 1'b0;
      codec_tx_ready = 1'b0;
      codec_rx_valid = 1'b0;
      codec_rx_data  = '0;
      sw_rx_ack      = 1'b0;
      model_reset();
      tick();
      tick();
      chk_all_zero("reset");
      release_reset();

      // basic write, ready immediately
      tx_xfer(9'h041, 0);
      // timeout, then next rise clears it
      tx_xfer(9'h07E, 20);
      chk("timeout set", 32'(tx_timeout), 32'd1);
      tx_xfer(9'h013, 0);
      chk("timeout cleared", 32'(tx_timeout), 32'd0);
      // boundary: ready seen on the last possible WAIT cycle, then exact timeout
      tx_xfer(9'h0C3, TMO - 1);
      tx_xfer(9'h1FF, TMO);
      for (int i = 0; i < 8; i++) tx_xfer(DW'($urandom), int'($urandom_range(0, 20)));

      // abort while waiting
      tx_xfer(9'h000, 0);
      sw_tx_en = 1'b1;
      codec_tx_ready = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      sw_tx_en = 1'b0;
      for (int k = 0; k < TMO + 4; k++) begin
         tick();
         chk("abort write", 32'(codec_tx_write), 32'd0);
         chk("abort timeout", 32'(tx_timeout), 32'd0);
      end

      // rx: EOP char and ack
      rx_cycle(1'b1, 9'h100, 1'b0);
      chk("eop data", 32'(sw_rx_data), 32'h100);
      rx_cycle(1'b0, 9'h000, 1'b1);
      chk("eop acked", 32'(sw_rx_ready), 32'd0);
      rx_cycle(1'b0, 9'h000, 1'b0);
      // rx valid coincident with ack rise
      rx_cycle(1'b1, 9'h055, 1'b0);
      rx_cycle(1'b1, 9'h0AA, 1'b1);
      chk("coincident data", 32'(sw_rx_data), 32'h0AA);
      chk("coincident ready", 32'(sw_rx_ready), 32'd1);
      rx_cycle(1'b0, 9'h000, 1'b0);
      rx_cycle(1'b0, 9'h000, 1'b1);
      rx_cycle(1'b0, 9'h000, 1'b0);
      // overrun then saturation
      rx_cycle(1'b1, 9'h011, 1'b0);
      rx_cycle(1'b1, 9'h022, 1'b0);
      rx_cycle(1'b1, 9'h033, 1'b0);
      chk("ovr two", 32'(rx_overrun_cnt), 32'd2);
      chk("first held", 32'(sw_rx_data), 32'h011);
      for (int i = 0; i < 5; i++) rx_cycle(1'b1, DW'(i), 1'b0);
      chk("ovr sat", 32'(rx_overrun_cnt), 32'd3);
      for (int i = 0; i < 40; i++)
         rx_cycle(1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 9) < 3));
      rx_cycle(1'b0, 9'h000, 1'b0);

      // reset during WAIT, request level held across release
      sw_tx_data = 9'h0F0;
      sw_tx_en = 1'b1;
      codec_tx_ready = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      reset_reset_n = 1'b0;
      #1;
      chk_all_zero("rst wait");
      model_reset();
      codec_tx_ready = 1'b1;
      tick();
      reset_reset_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("held en write", 32'(codec_tx_write), 32'd0);
         chk("held en ready", 32'(sw_tx_ready), 32'd0);
      end
      sw_tx_en = 1'b0;
      codec_tx_ready = 1'b0;
      tick();

      // reset during STROBE
      sw_tx_data = 9'h0A5;
      sw_tx_en = 1'b1;
      tick();
      codec_tx_ready = 1'b1;
      tick();
      chk("strobe before rst", 32'(codec_tx_write), 32'd1);
      reset_reset_n = 1'b0;
      #1;
      chk_all_zero("rst strobe");
      sw_tx_en = 1'b0;
      codec_tx_ready = 1'b0;
      tick();
      release_reset();
      for (int i = 0; i < 20; i++)
         rx_cycle(1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 9) < 4));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
